// File: rtl/result_bus_arbiter_pkg.sv
// Shared definitions for the result bus arbiter and its neighbours.
//
// Contents:
//   TAG_WIDTH              - default width of a station tag (station index)
//   DEFAULT_STATION_COUNT  - default number of result-producing stations
//   DEFAULT_RESULT_SIZE    - default result width
//   wrap_increment()       - index + 1, wrapping to 0 at count
package result_bus_arbiter_pkg;

    localparam int unsigned TAG_WIDTH             = 3;
    localparam int unsigned DEFAULT_STATION_COUNT = 8;
    localparam int unsigned DEFAULT_RESULT_SIZE   = 32;

    // Next index in a ring of `count` entries; `index` must be below `count`.
    function automatic int unsigned wrap_increment(input int unsigned index,
                                                   input int unsigned count);
        return (index + 1 >= count) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/rotating_priority_picker.sv
// Rotating priority picker: finds the first set request bit scanning from
// `start` upwards and wrapping modulo COUNT. Purely combinational.
//
// Ports:
//   request  in   COUNT       request mask
//   start    in   INDEX_SIZE  highest-priority index (must be < COUNT)
//   found    out  1           at least one request bit is set
//   index    out  INDEX_SIZE  index of the chosen request (0 when none found)
module rotating_priority_picker #(
    parameter int unsigned COUNT      = 8,
    parameter int unsigned INDEX_SIZE = 3
) (
    input  logic [COUNT-1:0]      request,
    input  logic [INDEX_SIZE-1:0] start,
    output logic                  found,
    output logic [INDEX_SIZE-1:0] index
);

    localparam int unsigned SEL_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1;

    int unsigned candidate;

    always_comb begin
        found     = 1'b0;
        index     = '0;
        candidate = 0;
        for (int unsigned offset = 0; offset < COUNT; offset++) begin
            // start + offset stays below 2*COUNT, so one subtraction wraps it.
            candidate = 32'(start) + offset;
            if (candidate >= COUNT) begin
                candidate = candidate - COUNT;
            end
            if (!found && request[candidate[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                index = INDEX_SIZE'(candidate);
            end
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: each cycle grants up to BUS_COUNT ready stations in
// round-robin order, pulses their release combinationally and broadcasts the
// granted results on registered result buses one cycle later.
//
// Ports:
//   clock            in   1                          sole clock, rising edge
//   reset            in   1                          synchronous, active-low
//   station_ready    in   STATION_COUNT              per-station result ready
//   station_result   in   SIZE*STATION_COUNT         flat per-station results
//   station_release  out  STATION_COUNT              combinational grant pulse
//   bus_asserted     out  BUS_COUNT                  registered bus valid
//   bus_source       out  STATION_INDEX_SIZE*BUS_COUNT  registered producer tag
//   bus_value        out  SIZE*BUS_COUNT             registered result value
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int unsigned STATION_COUNT      = DEFAULT_STATION_COUNT,
    parameter int unsigned STATION_INDEX_SIZE = TAG_WIDTH,
    parameter int unsigned SIZE               = DEFAULT_RESULT_SIZE,
    parameter int unsigned BUS_COUNT          = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [STATION_COUNT-1:0]             station_ready,
    input  logic [SIZE*STATION_COUNT-1:0]        station_result,
    output logic [STATION_COUNT-1:0]             station_release,
    output logic [BUS_COUNT-1:0]                 bus_asserted,
    output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
    output logic [SIZE*BUS_COUNT-1:0]            bus_value
);

    logic [STATION_INDEX_SIZE-1:0]                pointer_q, pointer_d;
    logic [BUS_COUNT-1:0]                         pick_found;
    logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] pick_index;
    logic [BUS_COUNT-1:0][SIZE-1:0]               pick_value;
    logic [STATION_COUNT-1:0]                     granted;

    logic [BUS_COUNT-1:0]                         bus_asserted_q;
    logic [STATION_INDEX_SIZE*BUS_COUNT-1:0]      bus_source_q;
    logic [SIZE*BUS_COUNT-1:0]                    bus_value_q;

    // Bus k scans the requests left over after buses 0..k-1 took theirs, all
    // starting from the same pointer, so bus k lands on the (k+1)-th ready
    // station and no station can be picked twice.
    for (genvar k = 0; k < BUS_COUNT; k++) begin : g_bus
        logic [STATION_COUNT-1:0] request;
        logic [STATION_COUNT-1:0] grant_bit;
        logic [STATION_COUNT-1:0] masked;

        if (k == 0) begin : g_first
            assign request = station_ready;
        end else begin : g_chain
            assign request = g_bus[k-1].masked;
        end

        rotating_priority_picker #(
            .COUNT      (STATION_COUNT),
            .INDEX_SIZE (STATION_INDEX_SIZE)
        ) u_picker (
            .request (request),
            .start   (pointer_q),
            .found   (pick_found[k]),
            .index   (pick_index[k])
        );

        assign grant_bit = pick_found[k] ? (STATION_COUNT'(1) << pick_index[k]) : '0;
        assign masked    = request & ~grant_bit;
        assign pick_value[k] = station_result[32'(pick_index[k]) * SIZE +: SIZE];
    end

    // Everything ready that did not survive the last mask was granted.
    assign granted         = station_ready & ~g_bus[BUS_COUNT-1].masked;
    assign station_release = reset ? granted : '0;

    // Grants form a prefix of the buses, so the last found one is the last
    // granted station in scan order.
    always_comb begin
        pointer_d = pointer_q;
        for (int k = 0; k < BUS_COUNT; k++) begin
            if (pick_found[k]) begin
                pointer_d = STATION_INDEX_SIZE'(wrap_increment(32'(pick_index[k]),
                                                               STATION_COUNT));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pointer_q      <= '0;
            bus_asserted_q <= '0;
            bus_source_q   <= '0;
            bus_value_q    <= '0;
        end else begin
            pointer_q      <= pointer_d;
            bus_asserted_q <= pick_found;
            // Unused buses keep their stale tag/value; they are not asserted.
            for (int k = 0; k < BUS_COUNT; k++) begin
                if (pick_found[k]) begin
                    bus_source_q[k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] <= pick_index[k];
                    bus_value_q[k*SIZE +: SIZE] <= pick_value[k];
                end
            end
        end
    end

    assign bus_asserted = bus_asserted_q;
    assign bus_source   = bus_source_q;
    assign bus_value    = bus_value_q;

endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Downstream of the execution stations (multiplier/divider, ALU, load unit): collects finished results and broadcasts them on the common result buses that feed every station's operand-capture logic. Each cycle it grants up to BUS_COUNT ready stations in round-robin order. It pulses each granted station's release (wired to the station's `reset_occupied`) and drives the registered bus triple `bus_asserted` / `bus_source` / `bus_value` one cycle later.

## Interface
- STATION_COUNT, 8: number of result-producing stations; need not be a power of 2.
- STATION_INDEX_SIZE, 3: width of a station tag; ≥ $clog2(STATION_COUNT).
- SIZE, 32: result width.
- BUS_COUNT, 1: number of result buses; 1 ≤ BUS_COUNT ≤ STATION_COUNT.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low: 0 at a rising edge resets the block.
- station_ready  in  STATION_COUNT  bit i = station i's `result_ready`.
- station_result  in  SIZE*STATION_COUNT  flat array; slice i = station i's `result`.
- station_release  out  STATION_COUNT  combinational; bit i pulses to release station i.
- bus_asserted  out  BUS_COUNT  flat array, registered; bus k is valid this cycle.
- bus_source  out  STATION_INDEX_SIZE*BUS_COUNT  flat array, registered; tag of the producing station.
- bus_value  out  SIZE*BUS_COUNT  flat array, registered; result value.

## Operation
- State:
  - `pointer`: highest-priority station index, range 0..STATION_COUNT-1.
  - Bus output registers.
- Selection (combinational, from `station_ready` and `pointer`):
  - Scan indices pointer, pointer+1, …, wrapping mod STATION_COUNT.
  - Bus k takes the (k+1)-th ready station found.
  - Fewer than BUS_COUNT ready: the higher-numbered buses are unused.
- Release: `station_release[i]` = 1 exactly when station i is granted this cycle, and never while reset is 0.
- Register update at a rising edge, when not in reset:
  - Granted bus k: `bus_asserted[k]` ← 1; `bus_source[k]` ← granted index; `bus_value[k]` ← that station's result slice.
  - Unused bus k: `bus_asserted[k]` ← 0; `bus_source` and `bus_value` hold their previous values. They are don't-care when not asserted; the bench checks them only while asserted.
- Pointer update:
  - ≥1 grant: `pointer` ← (last granted index + 1) mod STATION_COUNT.
  - No grants: `pointer` holds.
- A station is never granted to two buses in one cycle.
- A released station drops `station_ready` at the next edge (its occupied clears). The arbiter does not track this itself.
- Reset values: `pointer` = 0; `bus_asserted` = 0; `bus_source` = 0; `bus_value` = 0. `station_release` = 0 during reset.
- Reset mid-operation: anything selected in the reset cycle is discarded with no release issued. Buses are deasserted the following cycle.

## Timing
- Latency: ready in cycle N → release high in cycle N (combinational) → bus asserted for exactly cycle N+1.
- No backpressure: bus consumers capture unconditionally.
- Starvation bound: a continuously ready station is granted within ceil(STATION_COUNT / BUS_COUNT) cycles.
- Sequential path: the only register inputs are the selection logic and `station_result` muxes.
- Critical path: the rotate-scan over STATION_COUNT feeding the SIZE-wide result mux. With BUS_COUNT > 1, buses are chained (bus k masks the grants of buses 0..k-1).

## Structure
- Shared include:
  - The existing `FLAT_ARRAY`, `ARRAY` and `NORMAL_EQUALS_FLAT` macros for flat-port packing.
  - Station-tag width constants, shared with the stations and the issue logic.
- Sub-module `rotating_priority_picker`, instantiated once per bus:
  - Inputs: request mask, start index.
  - Outputs: found flag, index.
  - Purely combinational.
- Top level:
  - Chains the picker instances through masked request vectors.
  - Owns `pointer` and the bus registers.

## Test plan
- Reset: hold reset=0 for 2 cycles with `station_ready` = 8'hFF → no release asserted, `bus_asserted` = 0. Release reset with no stations ready → `pointer` = 0.
- Single result: BUS_COUNT=1, station 5 ready with 32'hDEADBEEF in cycle N → `station_release` = 8'h20 in cycle N. In cycle N+1, `bus_asserted`=1, `bus_source`=5, `bus_value`=32'hDEADBEEF.
- Round-robin wrap: `pointer`=6 and stations 1, 6, 7 held ready (each deasserted when released) → grant order 6, 7, 1 on consecutive cycles, leaving `pointer` = 2.
- Dual bus: BUS_COUNT=2, `pointer`=0, stations 2, 3, 4 ready → bus0=2, bus1=3, release = 8'h0C, `pointer`→4. Next cycle only station 4 ready → bus0=4, bus1 deasserted.
- Non-power-of-2: STATION_COUNT=5, `pointer`=4, stations 0 and 4 ready → 4 granted first, then 0, and `pointer` wraps 4→0→1.
- Mid-operation reset: station 3 ready and reset=0 in cycle N → no release in cycle N, `bus_asserted`=0 in cycle N+1. `pointer` = 0 afterwards.
